// File: rtl/obj_det_bbox_scanner.sv
// Bounding-box scanner for the 1-bit difference frame buffer.
// On start it reads every pixel of the stored frame once through a dedicated
// BRAM read port with a 2-cycle read latency. While it reads, it accumulates
// the bounding box of the set pixels and counts them. It then publishes the
// results together with a one-cycle done pulse.
//
// Handshake: start is a level sampled on a rising pixel_clk edge only while
// the FSM is IDLE; a sample of 1 there launches exactly one scan, and start is
// ignored at every other time. done is high for exactly one cycle, and the
// result outputs are valid in that cycle. They then hold until the next done.
module obj_det_bbox_scanner #(
    parameter int FRAME_W = 320,
    parameter int FRAME_H = 240,
    parameter int ADDR_W  = 17,
    parameter int CNT_W   = 17
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       min_pixels,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic              bram_dout,
    output logic              busy,
    output logic              done,
    output logic              box_valid,
    output logic [8:0]        x_min,
    output logic [8:0]        x_max,
    output logic [7:0]        y_min,
    output logic [7:0]        y_max,
    output logic [CNT_W-1:0]  pixel_count,
    output logic [1:0]        fsm_state
);

    localparam int N     = FRAME_W * FRAME_H;
    localparam int CMP_W = (CNT_W > 16) ? CNT_W : 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [8:0]        COL_LAST  = 9'(FRAME_W - 1);
    localparam logic [7:0]        ROW_LAST  = 8'(FRAME_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   drain_q;

    // Issue counters: address plus the matching column and row.
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        col_q;
    logic [7:0]        row_q;

    // Two-stage delay of the issued (col,row,valid) to line up with bram_dout.
    logic       v1_q, v2_q;
    logic [8:0] c1_q, c2_q;
    logic [7:0] r1_q, r2_q;

    // Accumulators.
    logic [8:0]       amin_x_q, amax_x_q;
    logic [7:0]       amin_y_q, amax_y_q;
    logic [CNT_W-1:0] acnt_q;

    // Published results, held between done pulses.
    logic             res_valid_q;
    logic [8:0]       res_xmin_q, res_xmax_q;
    logic [7:0]       res_ymin_q, res_ymax_q;
    logic [CNT_W-1:0] res_cnt_q;

    // Final values computed from the accumulators; an empty frame reports a zero box.
    logic             fin_any;
    logic             fin_valid;
    logic [8:0]       fin_xmin, fin_xmax;
    logic [7:0]       fin_ymin, fin_ymax;
    logic [CMP_W-1:0] cnt_ext, mp_ext;

    assign fin_any   = (acnt_q != '0);
    assign cnt_ext   = CMP_W'(acnt_q);
    assign mp_ext    = CMP_W'(min_pixels);
    assign fin_valid = fin_any && (cnt_ext >= mp_ext);
    assign fin_xmin  = fin_any ? amin_x_q : 9'd0;
    assign fin_xmax  = fin_any ? amax_x_q : 9'd0;
    assign fin_ymin  = fin_any ? amin_y_q : 8'd0;
    assign fin_ymax  = fin_any ? amax_y_q : 8'd0;

    // During DONE the freshly computed values are shown so they coincide with done.
    assign box_valid   = (state_q == S_DONE) ? fin_valid : res_valid_q;
    assign x_min       = (state_q == S_DONE) ? fin_xmin  : res_xmin_q;
    assign x_max       = (state_q == S_DONE) ? fin_xmax  : res_xmax_q;
    assign y_min       = (state_q == S_DONE) ? fin_ymin  : res_ymin_q;
    assign y_max       = (state_q == S_DONE) ? fin_ymax  : res_ymax_q;
    assign pixel_count = (state_q == S_DONE) ? CNT_W'(acnt_q) : res_cnt_q;
    assign fsm_state   = state_q;

    // State register and the drain-cycle toggle.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
        end
    end

    // Next-state logic and the BRAM, busy and done outputs.
    always_comb begin
        state_d   = state_q;
        bram_en   = 1'b0;
        bram_addr = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SCAN;
            end
            S_SCAN: begin
                bram_en   = 1'b1;
                bram_addr = addr_q;
                busy      = 1'b1;
                if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q) state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Issue counters: cleared on scan launch, stepped once per SCAN cycle.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else if (state_q == S_IDLE && start) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else if (state_q == S_SCAN) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? 8'd0 : row_q + 8'd1;
            end else begin
                col_q <= col_q + 9'd1;
            end
        end
    end

    // Delay line matching the BRAM read latency.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            c1_q <= '0;
            c2_q <= '0;
            r1_q <= '0;
            r2_q <= '0;
        end else begin
            v1_q <= (state_q == S_SCAN);
            c1_q <= col_q;
            r1_q <= row_q;
            v2_q <= v1_q;
            c2_q <= c1_q;
            r2_q <= r1_q;
        end
    end

    // Accumulate box extents and the saturating set-pixel count.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            amin_x_q <= '0;
            amax_x_q <= '0;
            amin_y_q <= '0;
            amax_y_q <= '0;
            acnt_q   <= '0;
        end else if (state_q == S_IDLE && start) begin
            amin_x_q <= COL_LAST;
            amax_x_q <= '0;
            amin_y_q <= ROW_LAST;
            amax_y_q <= '0;
            acnt_q   <= '0;
        end else if (v2_q && bram_dout) begin
            if (acnt_q != '1) acnt_q <= acnt_q + CNT_W'(1);
            if (c2_q < amin_x_q) amin_x_q <= c2_q;
            if (c2_q > amax_x_q) amax_x_q <= c2_q;
            if (r2_q < amin_y_q) amin_y_q <= r2_q;
            if (r2_q > amax_y_q) amax_y_q <= r2_q;
        end
    end

    // Capture the results at the end of DONE so they hold afterwards.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            res_xmin_q  <= '0;
            res_xmax_q  <= '0;
            res_ymin_q  <= '0;
            res_ymax_q  <= '0;
            res_cnt_q   <= '0;
        end else if (state_q == S_DONE) begin
            res_valid_q <= fin_valid;
            res_xmin_q  <= fin_xmin;
            res_xmax_q  <= fin_xmax;
            res_ymin_q  <= fin_ymin;
            res_ymax_q  <= fin_ymax;
            res_cnt_q   <= acnt_q;
        end
    end

endmodule

// File: tb/tb_obj_det_bbox_scanner.sv
// Bench for obj_det_bbox_scanner on an 8x4 frame, with a behavioural BRAM
// that has a 2-cycle read latency.
module tb_obj_det_bbox_scanner;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = 5;
    localparam int CW = 6;
    localparam int RW = 35 + CW;

    logic           pixel_clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [15:0]    min_pixels = 16'd0;
    logic [AW-1:0]  bram_addr;
    logic           bram_en;
    logic           bram_dout = 1'b0;
    logic           busy, done, box_valid;
    logic [8:0]     x_min, x_max;
    logic [7:0]     y_min, y_max;
    logic [CW-1:0]  pixel_count;
    logic [1:0]     fsm_state;

    obj_det_bbox_scanner #(
        .FRAME_W(W), .FRAME_H(H), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .pixel_clk(pixel_clk), .reset(reset), .start(start),
        .min_pixels(min_pixels), .bram_addr(bram_addr), .bram_en(bram_en),
        .bram_dout(bram_dout), .busy(busy), .done(done),
        .box_valid(box_valid), .x_min(x_min), .x_max(x_max),
        .y_min(y_min), .y_max(y_max), .pixel_count(pixel_count),
        .fsm_state(fsm_state)
    );

    // Clock.
    always #5 pixel_clk = ~pixel_clk;

    // Behavioural BRAM with a 2-cycle read latency.
    logic mem [0:N-1];
    logic rd1 = 1'b0;
    always @(posedge pixel_clk) begin
        if (bram_en) rd1 <= mem[bram_addr];
        bram_dout <= rd1;
    end

    // Scoreboard state.
    logic [RW-1:0] exp_q[$];
    int            done_at_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int neg_cnt = 0;
    int busy_from = 0, busy_to = 0, en_to = 0;
    int exp_addr = 0, en_count = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: walk the frame and derive the results from the pixel coordinates.
    function automatic logic [RW-1:0] model(input int mp);
        int cnt = 0;
        int xmn = W, xmx = -1, ymn = H, ymx = -1;
        bit vld;
        for (int a = 0; a < N; a++) begin
            if (mem[a]) begin
                cnt++;
                if (a % W < xmn) xmn = a % W;
                if (a % W > xmx) xmx = a % W;
                if (a / W < ymn) ymn = a / W;
                if (a / W > ymx) ymx = a / W;
            end
        end
        if (cnt == 0) begin
            xmn = 0; xmx = 0; ymn = 0; ymx = 0;
        end
        vld = (cnt != 0) && (cnt >= mp);
        return {vld, 9'(xmn), 9'(xmx), 8'(ymn), 8'(ymx), CW'(cnt)};
    endfunction

    // Monitor: per-cycle busy/bram_en windows, address order and results on done.
    always @(negedge pixel_clk) begin
        logic [RW-1:0] r;
        int t;
        neg_cnt++;
        if (checking) begin
            check("busy", 64'(busy), 64'(neg_cnt >= busy_from && neg_cnt <= busy_to));
            check("bram_en", 64'(bram_en), 64'(neg_cnt >= busy_from && neg_cnt <= en_to));
            if (bram_en) begin
                check("bram_addr", 64'(bram_addr), 64'(exp_addr));
                exp_addr++;
                en_count++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_done: done=1 with nothing expected (negedge %0d)", neg_cnt);
                end else begin
                    r = exp_q.pop_front();
                    t = done_at_q.pop_front();
                    check("result", 64'({box_valid, x_min, x_max, y_min, y_max, pixel_count}), 64'(r));
                    check("done_time", 64'(neg_cnt), 64'(t));
                    check("en_cycles", 64'(en_count), 64'(N));
                    en_count = 0;
                    exp_addr = 0;
                end
            end
        end
    end

    // Driver tasks.
    task automatic clear_mem();
        for (int a = 0; a < N; a++) mem[a] = 1'b0;
    endtask

    task automatic random_mem(input int pct);
        for (int a = 0; a < N; a++) mem[a] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic start_scan(input int mp, input bit repulse);
        int k;
        @(posedge pixel_clk);
        #1;
        min_pixels = 16'(mp);
        start = 1'b1;
        exp_q.push_back(model(mp));
        @(posedge pixel_clk);
        #1;
        start = 1'b0;
        k = neg_cnt;
        busy_from = k + 1;
        busy_to   = k + N + 3;
        en_to     = k + N;
        done_at_q.push_back(k + N + 3);
        if (repulse) begin
            repeat (4) @(posedge pixel_clk);
            #1 start = 1'b1;
            @(posedge pixel_clk);
            #1 start = 1'b0;
            repeat (27) @(posedge pixel_clk);
            #1 start = 1'b1;
            @(posedge pixel_clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge pixel_clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: %0d results still pending after 100 cycles", exp_q.size());
            exp_q.delete();
            done_at_q.delete();
        end
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // Main sequence.
    initial begin
        clear_mem();
        reset = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #1 reset = 1'b0;
        checking = 1'b1;
        @(negedge pixel_clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_bram_en", 64'(bram_en), 64'd0);
        check("rst_bram_addr", 64'(bram_addr), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_results", 64'({box_valid, x_min, x_max, y_min, y_max, pixel_count}), 64'd0);

        // Empty frame.
        clear_mem();
        start_scan(1, 1'b0);
        wait_done();

        // Single pixel at address 13.
        clear_mem();
        mem[13] = 1'b1;
        start_scan(1, 1'b0);
        wait_done();

        // Corner pixels, below threshold.
        clear_mem();
        mem[0] = 1'b1;
        mem[31] = 1'b1;
        start_scan(3, 1'b0);
        wait_done();

        // Ignored re-pulses of start during SCAN and DRAIN.
        random_mem(40);
        start_scan(5, 1'b1);
        wait_done();

        // Reset in cycle 10 of a scan, then a fresh scan.
        random_mem(50);
        start_scan(4, 1'b0);
        repeat (9) @(posedge pixel_clk);
        #1 reset = 1'b1;
        @(posedge pixel_clk);
        #1 reset = 1'b0;
        busy_to = 0;
        en_to = 0;
        exp_q.delete();
        done_at_q.delete();
        exp_addr = 0;
        en_count = 0;
        @(negedge pixel_clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_bram_en", 64'(bram_en), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_results", 64'({box_valid, x_min, x_max, y_min, y_max, pixel_count}), 64'd0);
        start_scan(4, 1'b0);
        wait_done();

        // Full frame at and just above the threshold.
        for (int a = 0; a < N; a++) mem[a] = 1'b1;
        start_scan(32, 1'b0);
        wait_done();
        start_scan(33, 1'b0);
        wait_done();

        // min_pixels of zero on an empty frame and on a single pixel.
        clear_mem();
        start_scan(0, 1'b0);
        wait_done();
        mem[$urandom_range(0, N - 1)] = 1'b1;
        start_scan(0, 1'b0);
        wait_done();

        // Random frames, thresholds and gaps.
        for (int i = 0; i < 10; i++) begin
            random_mem($urandom_range(0, 30));
            repeat ($urandom_range(0, 5)) @(posedge pixel_clk);
            start_scan($urandom_range(0, 12), 1'b0);
            wait_done();
        end

        repeat (5) @(posedge pixel_clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
